// File: rtl/seg7_bcd_mux.sv
// Latches a two-digit BCD value on a load strobe and multiplexes it onto a
// common-anode 4-digit seven-segment display. Define SEG7_LZ_BLANK_EN to blank a leading tens zero.
module seg7_bcd_mux #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_2,
  input  logic       load,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  typedef enum logic {
    ONES = 1'b0,
    TENS = 1'b1
  } slot_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  slot_e            slot_q, slot_d;
  logic [3:0]       ones_q, ones_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_tick_q, frame_tick_d;
  logic             wrap;
  logic [3:0]       cur_digit;
  logic             blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  always_comb begin
    wrap   = (cnt_q == CNT_MAX);
    cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
    slot_d = slot_q;
    if (wrap) slot_d = (slot_q == ONES) ? TENS : ONES;

    ones_d = load ? digit_2 : ones_q;
    tens_d = load ? digit_1 : tens_q;

    // Display is decoded from the present slot and latches, so it trails them by one cycle.
    cur_digit = (slot_q == TENS) ? tens_q : ones_q;
`ifdef SEG7_LZ_BLANK_EN
    blank = (slot_q == TENS) && (tens_q == 4'd0);
`else
    blank = 1'b0;
`endif
    seg_d        = blank ? '1 : decode(cur_digit);
    an_d         = (slot_q == TENS) ? 4'b1101 : 4'b1110;
    frame_tick_d = wrap && (slot_q == TENS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      slot_q       <= ONES;
      ones_q       <= '0;
      tens_q       <= '0;
      an_q         <= '1;
      seg_q        <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      ones_q       <= ones_d;
      tens_q       <= tens_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_bcd_mux.sv
// Self-checking bench for seg7_bcd_mux: reference model tracks edges since reset
// and the latched digits, deriving slot and display from plain arithmetic.
module tb_seg7_bcd_mux;

  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit_1 = '0;
  logic [3:0] digit_2 = '0;
  logic       load = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state: edges since reset release and latched digits.
  int unsigned k = 0;
  int unsigned m_ones = 0;
  int unsigned m_tens = 0;
  logic [6:0]  dec_tab [16];
  bit          lz_blank;

  seg7_bcd_mux #(
    .REFRESH_DIV(DIV),
    .CNT_W      (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digit_1   (digit_1),
    .digit_2   (digit_2),
    .load      (load),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  // One clock edge with the given inputs, then compare against the model.
  task automatic step(input logic r, input logic ld, input logic [3:0] d1, input logic [3:0] d2);
    int unsigned slot_prev;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_ft;
    rst = r; load = ld; digit_1 = d1; digit_2 = d2;
    @(posedge clk);
    #1;
    if (r) begin
      k = 0; m_ones = 0; m_tens = 0;
      e_an = 4'b1111; e_seg = 7'h7F; e_ft = 1'b0;
    end else begin
      slot_prev = (k / DIV) % 2;
      e_an  = (slot_prev == 1) ? 4'b1101 : 4'b1110;
      if (slot_prev == 1) e_seg = (lz_blank && m_tens == 0) ? 7'h7F : dec_tab[m_tens];
      else                e_seg = dec_tab[m_ones];
      k++;
      if (ld) begin m_tens = d1; m_ones = d2; end
      e_ft = (k % (2 * DIV)) == 0;
    end
    check_eq("an", an, e_an);
    check_eq("seg", seg, e_seg);
    check_eq("dp", dp, 1'b1);
    check_eq("frame_tick", frame_tick, e_ft);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 4'($urandom_range(15)), 4'($urandom_range(15)));
  endtask

  task automatic idle_until(input int unsigned phase);
    for (int unsigned i = 0; i < 2 * DIV && (k % (2 * DIV)) != phase; i++) idle(1);
  endtask

  initial begin
    dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
`ifdef SEG7_LZ_BLANK_EN
    lz_blank = 1'b1;
`else
    lz_blank = 1'b0;
`endif

    // Reset held three cycles, then free-running refresh.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 4'd0, 4'd0);
    check_eq("an_first", an, 4'b1110);
    idle(17);

    // Value 42, then inputs wiggle without a strobe.
    step(1'b0, 1'b1, 4'd4, 4'd2);
    idle(2 * DIV + 3);

    // Leading zero: 07.
    step(1'b0, 1'b1, 4'd0, 4'd7);
    idle(2 * DIV + 2);

    // Invalid BCD shows dashes in both slots.
    step(1'b0, 1'b1, 4'd12, 4'd15);
    idle(2 * DIV + 1);

    // Load exactly on the wrap edge into TENS.
    idle_until(DIV - 1);
    step(1'b0, 1'b1, 4'd9, 4'd9);
    step(1'b0, 1'b0, 4'd1, 4'd1);
    check_eq("wrap_load_seg", seg, 7'h10);
    check_eq("wrap_load_an", an, 4'b1101);

    // Reset in the middle of a TENS slot.
    step(1'b0, 1'b1, 4'd5, 4'd3);
    idle_until(DIV + 1);
    step(1'b1, 1'b0, 4'd0, 4'd0);
    check_eq("midrst_seg", seg, 7'h7F);
    step(1'b0, 1'b0, 4'd8, 4'd8);
    step(1'b0, 1'b0, 4'd8, 4'd8);
    check_eq("midrst_ones0", seg, 7'h40);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(99) < 2), ($urandom_range(99) < 20),
           4'($urandom_range(15)), 4'($urandom_range(15)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
